rf_dump_reader: RTL
===================

Name: rf_dump_reader

Overview:
Read-side sequencer for the team's register file. It drives the RF read address, captures the combinational read data, and streams register contents out on a valid/ready interface. It supports a single-register read or a full dump of all W registers. It is used by the debug/trace path to snapshot architectural state without stalling the write port.

Parameters:
N, 32, data width of one register (matches RF word width)
W, 32, number of registers; AW = $clog2(W) is the derived address width

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, synchronous, active-high
start  input  1  request pulse, sampled only in IDLE
single  input  1  qualifies start: 1 = single read of idx, 0 = full dump 0..W-1
idx  input  AW  register index for single read
rd_addr  output  AW  read address to RF port (combinational from state/counter)
rd_data  input  N  RF read data for rd_addr, combinational, same cycle
out_valid  output  1  stream beat valid
out_ready  input  1  downstream accept
out_data  output  N  captured register value
out_idx  output  AW  index of the register in out_data
busy  output  1  high in any state except IDLE
done  output  1  one-cycle pulse when the last beat is accepted
err  output  1  one-cycle pulse when a single request with idx >= W is rejected

Behaviour:
- States: IDLE, LOAD, HOLD.
- Reset: state=IDLE; cnt=0, last=0; out_valid=0, out_data=0, out_idx=0, done=0, err=0. Reset mid-transfer aborts immediately: no done pulse, and the beat in flight is dropped.
- rd_addr is cnt in LOAD. In HOLD it is cnt+1, so the next word can be captured in the same cycle the current beat is accepted. In IDLE it is 0.
- IDLE + start:
  - single=1 with idx<W: cnt=last=idx, go to LOAD.
  - single=1 with idx>=W: err=1 for one cycle, stay in IDLE.
  - single=0: cnt=0, last=W-1, go to LOAD.
- A start that arrives while busy is ignored, with no queuing.
- LOAD (one cycle): out_data<=rd_data, out_idx<=cnt, out_valid<=1, go to HOLD.
- HOLD with out_valid=1 and out_ready=0: out_data and out_idx are held stable, and out_valid stays 1 (AXI-style: valid never drops without acceptance).
- HOLD with out_ready=1:
  - If cnt==last: out_valid<=0, done<=1, go to IDLE.
  - Else: cnt<=cnt+1, out_data<=rd_data (address cnt+1), out_idx<=cnt+1, stay in HOLD, out_valid stays 1.
- Latency: start at edge t gives first out_valid at edge t+2. With out_ready held at 1, throughput is 1 beat/cycle. A full dump takes W+2 cycles from start to done.
- Coherency: each word is sampled on the cycle it is captured. RF writes landing after capture are not reflected, and no snapshot is taken across the whole dump.
- cnt is AW bits. cnt never exceeds W-1, so no wrap-around occurs even when W is not a power of two.
- done and err are registered pulses and never asserted together.

Optional Feature:
Macro RF_DUMP_PARITY_EN.
- Defined: adds output out_par (1 bit) = XOR-reduce of out_data, registered with out_data and held with it under backpressure. Reset value is 0.
- Undefined: the port is absent and there is no extra logic.

Decomposition:
- Package rf_pkg holds:
  - typedef enum logic [1:0] {IDLE, LOAD, HOLD} rfdump_state_t
  - localparam defaults RF_N=32, RF_W=32
  - a function rf_aw(W) returning $clog2(W), shared with the register file.
- No sub-module is needed. The bench instantiates the existing register file next to the DUT, with rd_addr tied to one RF read port.

Test Plan:
1. Preload RF r5=0xDEADBEEF; single=1, idx=5, start; out_ready=1 -> out_valid at t+2 with out_data=0xDEADBEEF, out_idx=5, done next cycle.
2. Preload rk=k*0x11 for all k; full dump with out_ready=1 -> 32 consecutive beats with idx 0..31 and data k*0x11, done on the cycle after beat 31, busy low after.
3. Full dump with out_ready toggling 1,0,0,1... -> no beat lost or duplicated; out_data and out_idx stable while stalled; total 32 beats.
4. W=24 build, single idx=30 -> err pulse, busy stays 0, no out_valid. Full dump -> exactly 24 beats with last out_idx=23.
5. Assert rst during beat 10 of a dump -> next cycle out_valid=0, busy=0, no done; a new start then works normally from idx 0.
6. Assert start while busy, plus RF write to r20=0x1234 during a dump before r20 is captured -> start ignored; beat 20 shows 0x1234. With RF_DUMP_PARITY_EN, out_par equals the XOR of out_data on every beat.

Source files
------------

// File: rtl/rf_dump_reader_pkg.sv
// Shared types and sizing helpers for the register file and its read-side dump sequencer.
package rf_pkg;

  localparam int RF_N = 32;
  localparam int RF_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } rfdump_state_t;

  function automatic int rf_aw(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/rf_dump_reader_if.sv
// Request, RF read port, output stream and status of rf_dump_reader.
// RF_DUMP_PARITY_EN adds out_par alongside out_data.
interface rf_dump_reader_if
  import rf_pkg::*;
#(
  parameter int N = RF_N,
  parameter int W = RF_W
);

  localparam int AW = rf_aw(W);

  logic          start;
  logic          single;
  logic [AW-1:0] idx;
  logic [AW-1:0] rd_addr;
  logic [N-1:0]  rd_data;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_data;
  logic [AW-1:0] out_idx;
  logic          busy;
  logic          done;
  logic          err;
`ifdef RF_DUMP_PARITY_EN
  logic          out_par;

  modport master (
    input  start, single, idx, rd_data, out_ready,
    output rd_addr, out_valid, out_data, out_idx, busy, done, err, out_par
  );
  modport slave (
    output start, single, idx, rd_data, out_ready,
    input  rd_addr, out_valid, out_data, out_idx, busy, done, err, out_par
  );
`else
  modport master (
    input  start, single, idx, rd_data, out_ready,
    output rd_addr, out_valid, out_data, out_idx, busy, done, err
  );
  modport slave (
    output start, single, idx, rd_data, out_ready,
    input  rd_addr, out_valid, out_data, out_idx, busy, done, err
  );
`endif

endinterface

// File: rtl/rf_dump_reader.sv
// Register-file read sequencer: single read or full dump streamed on valid/ready.
// RF_DUMP_PARITY_EN adds out_par, the XOR of out_data, captured and held with it.
module rf_dump_reader
  import rf_pkg::*;
#(
  parameter int N = RF_N,
  parameter int W = RF_W
) (
  input  logic               clk,
  input  logic               rst,
  rf_dump_reader_if.master   bus
);

  localparam int            AW       = rf_aw(W);
  localparam logic [AW:0]   W_EXT    = (AW+1)'(W);
  localparam logic [AW-1:0] LAST_IDX = AW'(W - 1);

  rfdump_state_t state;
  rfdump_state_t state_nxt;

  logic [AW-1:0] cnt;
  logic [AW-1:0] last;
  logic [AW-1:0] cnt_inc;
  logic          idx_ok;
  logic          hold_last;
  logic          capture;

  logic          out_valid_q;
  logic [N-1:0]  out_data_q;
  logic [AW-1:0] out_idx_q;
  logic          done_q;
  logic          err_q;

  assign cnt_inc   = cnt + AW'(1);
  assign idx_ok    = {1'b0, bus.idx} < W_EXT;
  assign hold_last = (cnt == last);
  // LOAD captures word cnt; an accepted non-final HOLD beat captures word cnt+1.
  assign capture   = (state == LOAD) ||
                     ((state == HOLD) && bus.out_ready && !hold_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.start && (!bus.single || idx_ok)) begin
          state_nxt = LOAD;
        end
      end
      LOAD: state_nxt = HOLD;
      HOLD: begin
        if (bus.out_ready && hold_last) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.rd_addr = '0;
    bus.busy    = (state != IDLE);
    case (state)
      LOAD:    bus.rd_addr = cnt;
      HOLD:    bus.rd_addr = cnt_inc;
      default: bus.rd_addr = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      last        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (capture) begin
        out_data_q <= bus.rd_data;
        out_idx_q  <= bus.rd_addr;
      end
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (!bus.single) begin
              cnt  <= '0;
              last <= LAST_IDX;
            end else if (idx_ok) begin
              cnt  <= bus.idx;
              last <= bus.idx;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        LOAD: out_valid_q <= 1'b1;
        HOLD: begin
          if (bus.out_ready) begin
            if (hold_last) begin
              out_valid_q <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              cnt <= cnt_inc;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef RF_DUMP_PARITY_EN
  logic par_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      par_q <= 1'b0;
    end else if (capture) begin
      par_q <= ^bus.rd_data;
    end
  end

  assign bus.out_par = par_q;
`endif

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule
